multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Registered, handshaked RV32/RV64 integer execute unit for the core's IE stage. Replaces the combinational ALU.
- Single-cycle results for base-ISA ALU ops. Iterative MUL/MULH/MULHSU/MULHU.
- Optional iterative DIV/DIVU/REM/REMU.
- Operands arrive already muxed (IE mux outputs). Decode uses opcode, fun3 and fun7.

Parameters:
- XLEN, 32, datapath width; power of two, >=8.
- MUL_BITS, 1, multiplier bits retired per cycle; must divide XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (high only in IDLE)
- opcode  in  7  inst[6:0]
- fun3  in  3  inst[14:12]
- fun7  in  7  inst[31:25]
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or sign-extended immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- illegal  out  1  unsupported encoding flag, qualified by out_valid

Behaviour:
- Reset (sync, clk edge with rst=1):
  - state=IDLE; out_valid=0, result=0, illegal=0, in_ready=1.
  - Reset mid-operation aborts it; no out_valid for the aborted op.
- Accept: in_valid && in_ready on an edge latches all inputs.
- States:
  - IDLE -> DONE for base/illegal/special-case ops.
  - IDLE -> MUL for multiply ops.
  - IDLE -> DIV for divide ops.
  - MUL/DIV -> DONE after the final iteration.
  - DONE -> IDLE on out_valid && out_ready.
- Base ops (opcode 0110011 R, 0010011 I):
  - ADD, SUB (R only, fun7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-form: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (fun7[5]=1).
  - Shift amount = op_b[log2(XLEN)-1:0].
  - SLT/SLTU result is zero-extended 0/1.
  - Arithmetic wraps mod 2^XLEN.
- M ops: opcode 0110011, fun7=0000001, fun3 000-011 = MUL, MULH, MULHSU, MULHU.
  - Shift-add on operand magnitudes; sign fixed at the end.
  - Iterations: XLEN/MUL_BITS.
  - MUL returns the low XLEN bits of the 2*XLEN product; the others return the high XLEN bits.
  - MULH: signed x signed. MULHSU: signed op_a x unsigned op_b. MULHU: unsigned x unsigned.
- Latency (accept at edge N):
  - Base op: out_valid=1 after edge N+1.
  - MUL family: out_valid=1 after edge N+XLEN/MUL_BITS+1.
- Output hold: out_valid, result and illegal stay stable in DONE until out_ready. in_ready=0 outside IDLE.
- Back-to-back: next accept is possible on the edge after the DONE handshake; no same-cycle turnaround.
- Illegal: any other opcode/fun3/fun7 combination gives illegal=1, result=0, latency 1.
  - Examples: fun7=0100000 with fun3=000 on I-form is legal ADDI (fun7 ignored); fun7=0100000 with fun3=001 is illegal.

Optional Feature:
- ALU_DIV_EN defined:
  - fun7=0000001 with fun3 100-111 = DIV, DIVU, REM, REMU.
  - Restoring divider, XLEN iterations; latency XLEN+1.
  - Divide by zero: quotient = all ones, remainder = op_a; latency 1, no DIV state.
  - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): quotient = op_a, remainder = 0; latency 1.
  - Remainder takes the sign of the dividend.
- Not defined: these encodings are illegal (illegal=1, result=0, latency 1). The DIV state and datapath are absent.

Test Plan:
- Reset, then ADD op_a=0x7FFFFFFF, op_b=1 -> after 1 cycle: out_valid=1, result=0x80000000, illegal=0; SUB 5-7 -> 0xFFFFFFFE.
- SRA op_a=0x80000010, op_b=0x24 (shamt 4) -> 0xF8000001; SRL same -> 0x08000001; SLT -1<1 -> 1; SLTU -> 0.
- MULH op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001. out_valid exactly 33 cycles after accept (MUL_BITS=1), in_ready=0 meanwhile.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> IDLE next edge.
- Assert rst 10 cycles into a MULHU -> out_valid=0 next cycle; ADDI 3+4 then completes with result 7.
- With ALU_DIV_EN: DIV -7/2 -> 0xFFFFFFFD with REM 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000 in 1 cycle. Without it: same encodings give illegal=1, result=0.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered, handshaked RV32/RV64 integer execute unit: single-cycle base ops, iterative multiply.
// Optional iterative divide/remainder is built when ALU_DIV_EN is defined.
//
// state  | meaning
// IDLE   | ready for a new operation
// MUL    | shift-add multiply iterations
// DIV    | restoring divide iterations (ALU_DIV_EN only)
// DONE   | first cycle finalizes the result, then holds it until out_ready
module multicycle_alu #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      fun3,
   input  logic [6:0]      fun7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int SH       = $clog2(XLEN);
   localparam int CW       = $clog2(XLEN + 1);
   localparam int MUL_ITER = XLEN / MUL_BITS;

   typedef enum logic [1:0] {
      S_IDLE, S_MUL, S_DONE
`ifdef ALU_DIV_EN
      , S_DIV
`endif
   } state_e;

   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
      OP_ILL
   } op_e;

   state_e            state_q;
   op_e               op_q;
   logic [XLEN-1:0]   a_q, b_q, hi_q, lo_q, result_q;
   logic [CW-1:0]     cnt_q;
   logic              out_valid_q, illegal_q;

   function automatic logic op_sa(input op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_sb(input op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_mul(input op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
      return (s && x[XLEN-1]) ? -x : x;
   endfunction

`ifdef ALU_DIV_EN
   function automatic logic is_div(input op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic div_ovf(input op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      return op_sa(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
   endfunction
`endif

   // RV64 I-form shifts use fun7[0] as shamt[5], so it is excluded from the check
   logic [6:0] fun7_sh;
   op_e        dec_op_d;

   always_comb begin
      fun7_sh  = (XLEN == 64) ? {fun7[6:1], 1'b0} : fun7;
      dec_op_d = OP_ILL;
      case (opcode)
         7'b0110011: begin
            if (fun7 == 7'b0000000) begin
               case (fun3)
                  3'b000:  dec_op_d = OP_ADD;
                  3'b001:  dec_op_d = OP_SLL;
                  3'b010:  dec_op_d = OP_SLT;
                  3'b011:  dec_op_d = OP_SLTU;
                  3'b100:  dec_op_d = OP_XOR;
                  3'b101:  dec_op_d = OP_SRL;
                  3'b110:  dec_op_d = OP_OR;
                  default: dec_op_d = OP_AND;
               endcase
            end else if (fun7 == 7'b0100000) begin
               if (fun3 == 3'b000)      dec_op_d = OP_SUB;
               else if (fun3 == 3'b101) dec_op_d = OP_SRA;
            end else if (fun7 == 7'b0000001) begin
               case (fun3)
                  3'b000:  dec_op_d = OP_MUL;
                  3'b001:  dec_op_d = OP_MULH;
                  3'b010:  dec_op_d = OP_MULHSU;
                  3'b011:  dec_op_d = OP_MULHU;
`ifdef ALU_DIV_EN
                  3'b100:  dec_op_d = OP_DIV;
                  3'b101:  dec_op_d = OP_DIVU;
                  3'b110:  dec_op_d = OP_REM;
                  3'b111:  dec_op_d = OP_REMU;
`endif
                  default: dec_op_d = OP_ILL;
               endcase
            end
         end
         7'b0010011: begin
            case (fun3)
               3'b000:  dec_op_d = OP_ADD;
               3'b010:  dec_op_d = OP_SLT;
               3'b011:  dec_op_d = OP_SLTU;
               3'b100:  dec_op_d = OP_XOR;
               3'b110:  dec_op_d = OP_OR;
               3'b111:  dec_op_d = OP_AND;
               3'b001:  if (fun7_sh == 7'b0000000) dec_op_d = OP_SLL;
               default: begin
                  if (fun7_sh == 7'b0000000)      dec_op_d = OP_SRL;
                  else if (fun7_sh == 7'b0100000) dec_op_d = OP_SRA;
               end
            endcase
         end
         default: dec_op_d = OP_ILL;
      endcase
   end

   logic                     sa_d, sb_d;
   logic [XLEN-1:0]          a_mag_d, b_mag_d;
   logic [SH-1:0]            shamt_d;
   logic [XLEN+MUL_BITS-1:0] mul_sum_d;
   logic [2*XLEN-1:0]        mul_nxt_d, prod_raw_d, prod_d;

   assign sa_d       = op_sa(op_q) & a_q[XLEN-1];
   assign sb_d       = op_sb(op_q) & b_q[XLEN-1];
   assign a_mag_d    = mag(a_q, op_sa(op_q));
   assign b_mag_d    = mag(b_q, op_sb(op_q));
   assign shamt_d    = b_q[SH-1:0];
   assign mul_sum_d  = {{MUL_BITS{1'b0}}, hi_q}
                     + ((XLEN+MUL_BITS)'(a_mag_d) * (XLEN+MUL_BITS)'(lo_q[MUL_BITS-1:0]));
   assign mul_nxt_d  = (2*XLEN)'({mul_sum_d, lo_q} >> MUL_BITS);
   assign prod_raw_d = {hi_q, lo_q};
   assign prod_d     = (sa_d ^ sb_d) ? -prod_raw_d : prod_raw_d;

`ifdef ALU_DIV_EN
   logic [XLEN:0] div_trial_d, div_diff_d;
   logic          div_zero_d, div_ovf_d;

   assign div_trial_d = {hi_q, lo_q[XLEN-1]};
   assign div_diff_d  = div_trial_d - {1'b0, b_mag_d};
   assign div_zero_d  = (b_q == '0);
   assign div_ovf_d   = div_ovf(op_q, a_q, b_q);
`endif

   logic [XLEN-1:0] fin_res_d;
   logic            fin_ill_d;

   always_comb begin
      fin_res_d = '0;
      fin_ill_d = 1'b0;
      case (op_q)
         OP_ADD:    fin_res_d = a_q + b_q;
         OP_SUB:    fin_res_d = a_q - b_q;
         OP_SLL:    fin_res_d = a_q << shamt_d;
         OP_SLT:    fin_res_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         OP_SLTU:   fin_res_d = {{(XLEN-1){1'b0}}, a_q < b_q};
         OP_XOR:    fin_res_d = a_q ^ b_q;
         OP_SRL:    fin_res_d = a_q >> shamt_d;
         OP_SRA:    fin_res_d = $signed(a_q) >>> shamt_d;
         OP_OR:     fin_res_d = a_q | b_q;
         OP_AND:    fin_res_d = a_q & b_q;
         OP_MUL:    fin_res_d = prod_d[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:
                    fin_res_d = prod_d[2*XLEN-1:XLEN];
`ifdef ALU_DIV_EN
         OP_DIV, OP_DIVU: begin
            if (div_zero_d)     fin_res_d = '1;
            else if (div_ovf_d) fin_res_d = a_q;
            else                fin_res_d = (sa_d ^ sb_d) ? -lo_q : lo_q;
         end
         OP_REM, OP_REMU: begin
            if (div_zero_d)     fin_res_d = a_q;
            else if (div_ovf_d) fin_res_d = '0;
            else                fin_res_d = sa_d ? -hi_q : hi_q;
         end
`endif
         default:   fin_ill_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ILL;
         a_q         <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q  <= op_a;
                  b_q  <= op_b;
                  op_q <= dec_op_d;
                  if (is_mul(dec_op_d)) begin
                     state_q <= S_MUL;
                     hi_q    <= '0;
                     lo_q    <= mag(op_b, op_sb(dec_op_d));
                     cnt_q   <= CW'(MUL_ITER);
                  end
`ifdef ALU_DIV_EN
                  else if (is_div(dec_op_d) && (op_b != '0) && !div_ovf(dec_op_d, op_a, op_b)) begin
                     state_q <= S_DIV;
                     hi_q    <= '0;
                     lo_q    <= mag(op_a, op_sa(dec_op_d));
                     cnt_q   <= CW'(XLEN);
                  end
`endif
                  else begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               {hi_q, lo_q} <= mul_nxt_d;
               cnt_q        <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_DONE;
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
               if (!div_diff_d[XLEN]) begin
                  hi_q <= div_diff_d[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_q <= div_trial_d[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], 1'b0};
               end
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_DONE;
            end
`endif
            S_DONE: begin
               if (!out_valid_q) begin
                  result_q    <= fin_res_d;
                  illegal_q   <= fin_ill_d;
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (XLEN=32, MUL_BITS=1).
// Divide vectors follow ALU_DIV_EN: expected quotients/remainders when defined, illegal otherwise.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [6:0]  opcode, fun7;
   logic [2:0]  fun3;
   logic [31:0] op_a, op_b, result;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011;
   localparam logic [6:0] F0 = 7'b0000000, FA = 7'b0100000, FM = 7'b0000001;

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b, exp;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t base_v[17];
   vec_t mul_v[4];
   vec_t div_v[8];

   multicycle_alu #(.XLEN(32), .MUL_BITS(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .fun3(fun3), .fun7(fun7), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Called #1 after a rising edge with the DUT idle; the next edge accepts.
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
      opcode = opc; fun3 = f3; fun7 = f7; op_a = a; op_b = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_op(input vec_t v, output logic [31:0] res, output logic ill, output int lat);
      issue(v.opc, v.f3, v.f7, v.a, v.b);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      res = result;
      ill = illegal;
      if (out_valid) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_table(input vec_t v);
      logic [31:0] res;
      logic        ill;
      int          lat;
      run_op(v, res, ill, lat);
      checks++;
      if (res !== v.exp || ill !== v.ill || lat !== v.lat) begin
         errors++;
         $display("FAIL %s: result=%h illegal=%b latency=%0d, required result=%h illegal=%b latency=%0d",
                  v.name, res, ill, lat, v.exp, v.ill, v.lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; fun3 = '0; fun7 = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: out_valid=%b result=%h illegal=%b in_ready=%b, required 0 00000000 0 1",
                  out_valid, result, illegal, in_ready);
      end
   endtask

   task automatic test_base();
      base_v[0]  = '{"add",    OPR, 3'b000, F0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1};
      base_v[1]  = '{"sub",    OPR, 3'b000, FA, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1};
      base_v[2]  = '{"sra",    OPR, 3'b101, FA, 32'h80000010, 32'h24,       32'hF8000001, 1'b0, 1};
      base_v[3]  = '{"srl",    OPR, 3'b101, F0, 32'h80000010, 32'h24,       32'h08000001, 1'b0, 1};
      base_v[4]  = '{"slt",    OPR, 3'b010, F0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1};
      base_v[5]  = '{"sltu",   OPR, 3'b011, F0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1};
      base_v[6]  = '{"xor",    OPR, 3'b100, F0, 32'hF0F01234, 32'h0FF000FF, 32'hFF0012CB, 1'b0, 1};
      base_v[7]  = '{"or",     OPR, 3'b110, F0, 32'hF0F01234, 32'h0FF000FF, 32'hFFF012FF, 1'b0, 1};
      base_v[8]  = '{"and",    OPR, 3'b111, F0, 32'hF0F01234, 32'h0FF000FF, 32'h00F00034, 1'b0, 1};
      base_v[9]  = '{"sll",    OPR, 3'b001, F0, 32'h1,        32'h21,       32'h2,        1'b0, 1};
      base_v[10] = '{"addi_f7",OPI, 3'b000, FA, 32'd10,       32'd5,        32'd15,       1'b0, 1};
      base_v[11] = '{"srai",   OPI, 3'b101, FA, 32'h80000010, 32'h404,      32'hF8000001, 1'b0, 1};
      base_v[12] = '{"sltiu",  OPI, 3'b011, F0, 32'd5,        32'hFFFFFFFF, 32'h1,        1'b0, 1};
      base_v[13] = '{"ill_slli",OPI,3'b001, FA, 32'h1,        32'h1,        32'h0,        1'b1, 1};
      base_v[14] = '{"ill_opc", 7'b0000011, 3'b000, F0, 32'h5, 32'h6,      32'h0,        1'b1, 1};
      base_v[15] = '{"ill_r_alt",OPR,3'b001,FA, 32'h5,        32'h6,        32'h0,        1'b1, 1};
      base_v[16] = '{"ill_f7",  OPR, 3'b000, 7'b0000010, 32'h5, 32'h6,      32'h0,        1'b1, 1};
      for (int i = 0; i < 17; i++) run_table(base_v[i]);
   endtask

   task automatic test_mul();
      int lat = 0;
      int ready_bad = 0;
      issue(OPR, 3'b001, FM, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         lat++;
         if (in_ready !== 1'b0) ready_bad++;
         if (out_valid) break;
      end
      checks++;
      if (result !== 32'h0 || illegal !== 1'b0 || lat !== 33) begin
         errors++;
         $display("FAIL mulh: result=%h illegal=%b latency=%0d, required 00000000 0 33", result, illegal, lat);
      end
      checks++;
      if (ready_bad !== 0) begin
         errors++;
         $display("FAIL mul_in_ready: in_ready high in %0d busy cycles, required 0", ready_bad);
      end
      @(posedge clk); #1;
      mul_v[0] = '{"mulhu",  OPR, 3'b011, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
      mul_v[1] = '{"mul",    OPR, 3'b000, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33};
      mul_v[2] = '{"mulhsu", OPR, 3'b010, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
      mul_v[3] = '{"mul_lo", OPR, 3'b000, FM, 32'h12345678, 32'h10,       32'h23456780, 1'b0, 33};
      for (int i = 0; i < 4; i++) run_table(mul_v[i]);
   endtask

   task automatic test_hold();
      int lat = 0;
      int late = 0;
      out_ready = 1'b0;
      issue(OPR, 3'b000, F0, 32'd1, 32'd2);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      checks++;
      if (lat !== 1 || result !== 32'd3) begin
         errors++;
         $display("FAIL hold_first: latency=%0d result=%h, required 1 00000003", lat, result);
      end
      opcode = OPR; fun3 = 3'b000; fun7 = F0; op_a = 32'd100; op_b = 32'd100;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: result=%h out_valid=%b in_ready=%b, required 00000003 1 0",
                     k, result, out_valid, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) late++;
      end
      checks++;
      if (late !== 0) begin
         errors++;
         $display("FAIL hold_no_accept: out_valid seen in %0d cycles, required 0", late);
      end
   endtask

   task automatic test_reset_abort();
      vec_t v;
      issue(OPR, 3'b011, FM, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         errors++;
         $display("FAIL reset_abort: out_valid=%b in_ready=%b result=%h, required 0 1 00000000",
                  out_valid, in_ready, result);
      end
      v = '{"addi_after_rst", OPI, 3'b000, F0, 32'd3, 32'd4, 32'd7, 1'b0, 1};
      run_table(v);
   endtask

   task automatic test_div();
`ifdef ALU_DIV_EN
      div_v[0] = '{"div",      OPR, 3'b100, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
      div_v[1] = '{"rem",      OPR, 3'b110, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
      div_v[2] = '{"divu_z",   OPR, 3'b101, FM, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
      div_v[3] = '{"remu_z",   OPR, 3'b111, FM, 32'd5,        32'd0,        32'd5,        1'b0, 1};
      div_v[4] = '{"div_ovf",  OPR, 3'b100, FM, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
      div_v[5] = '{"rem_ovf",  OPR, 3'b110, FM, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1};
      div_v[6] = '{"divu",     OPR, 3'b101, FM, 32'd100,      32'd7,        32'd14,       1'b0, 33};
      div_v[7] = '{"remu",     OPR, 3'b111, FM, 32'd100,      32'd7,        32'd2,        1'b0, 33};
`else
      div_v[0] = '{"div_ill",  OPR, 3'b100, FM, 32'hFFFFFFF9, 32'd2,        32'h0, 1'b1, 1};
      div_v[1] = '{"rem_ill",  OPR, 3'b110, FM, 32'hFFFFFFF9, 32'd2,        32'h0, 1'b1, 1};
      div_v[2] = '{"divu_ill", OPR, 3'b101, FM, 32'd5,        32'd0,        32'h0, 1'b1, 1};
      div_v[3] = '{"remu_ill", OPR, 3'b111, FM, 32'd5,        32'd0,        32'h0, 1'b1, 1};
      div_v[4] = '{"div_ovf_ill", OPR, 3'b100, FM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1};
      div_v[5] = '{"rem_ovf_ill", OPR, 3'b110, FM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1};
      div_v[6] = '{"divu_ill2",OPR, 3'b101, FM, 32'd100,      32'd7,        32'h0, 1'b1, 1};
      div_v[7] = '{"remu_ill2",OPR, 3'b111, FM, 32'd100,      32'd7,        32'h0, 1'b1, 1};
`endif
      for (int i = 0; i < 8; i++) run_table(div_v[i]);
   endtask

   initial begin
      test_reset();
      test_base();
      test_mul();
      test_hold();
      test_reset_abort();
      test_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
